// File: rtl/dynamixel_pkg.sv
// Shared types and helpers for the Dynamixel status-packet receiver.
// Packet FSM states, byte-receiver states and the checksum rule.
package dynamixel_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR1,
    S_HDR2,
    S_ID,
    S_LEN,
    S_ERR,
    S_PARAM,
    S_CHK,
    S_DONE
  } pkt_state_t;

  typedef enum logic [1:0] {
    U_IDLE,
    U_START,
    U_DATA,
    U_STOP
  } uart_state_t;

  localparam logic [7:0] HDR_BYTE = 8'hFF;
  localparam logic [7:0] MIN_LEN  = 8'd2;

  // Register set of the packet parser, copied whole into next-state
  typedef struct packed {
    pkt_state_t  state;
    logic        busy;
    logic        sv;
    logic [7:0]  id;
    logic [7:0]  len;
    logic [7:0]  err;
    logic [7:0]  chk;
    logic [31:0] param;
    logic [7:0]  acc;
    logic [2:0]  k;
    logic        chk_err;
    logic        frame_err;
    logic        len_err;
    logic        timeout;
  } rx_regs_t;

  function automatic logic [7:0] dxl_checksum(input logic [7:0] sum);
    return ~sum;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer, mid-bit sampling,
// one-cycle byte strobe or frame-error pulse.
module uart_rx_byte
  import dynamixel_pkg::*;
#(
  parameter int CLK_DIV = 875
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rxd,
  input  logic       i_abort,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_frame
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);

  logic          r_s1, r_s2, r_s3;
  uart_state_t   r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [2:0]    r_bit, w_bit;
  logic [7:0]    r_sh, w_sh;
  logic          r_valid, w_valid;
  logic          r_frame, w_frame;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_s3    <= 1'b1;
      r_state <= U_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_valid <= 1'b0;
      r_frame <= 1'b0;
    end else begin
      r_s1    <= i_rxd;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_bit   <= w_bit;
      r_sh    <= w_sh;
      r_valid <= w_valid;
      r_frame <= w_frame;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_bit   = r_bit;
    w_sh    = r_sh;
    w_valid = 1'b0;
    w_frame = 1'b0;
    if (i_abort) begin
      w_state = U_IDLE;
      w_cnt   = '0;
    end else begin
      unique case (r_state)
        U_IDLE: begin
          w_cnt = '0;
          if (r_s3 && !r_s2) w_state = U_START;
        end
        U_START: begin
          w_cnt = r_cnt + 1'b1;
          if (r_cnt == HALF) begin
            // Line back high at mid start bit: treat as a glitch
            w_state = r_s2 ? U_IDLE : U_DATA;
            w_cnt   = '0;
            w_bit   = '0;
          end
        end
        U_DATA: begin
          w_cnt = r_cnt + 1'b1;
          if (r_cnt == FULL) begin
            w_sh  = {r_s2, r_sh[7:1]};
            w_cnt = '0;
            w_bit = r_bit + 1'b1;
            if (r_bit == 3'd7) w_state = U_STOP;
          end
        end
        U_STOP: begin
          w_cnt = r_cnt + 1'b1;
          if (r_cnt == FULL) begin
            w_cnt   = '0;
            w_state = U_IDLE;
            w_valid = r_s2;
            w_frame = !r_s2;
          end
        end
      endcase
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_sh;
  assign o_frame = r_frame;

endmodule

// File: rtl/dynamixel_status_rx.sv
// Dynamixel status-packet receiver: parses FF FF ID LEN ERR P* CHK
// and exposes status/param words plus sticky fault flags.
module dynamixel_status_rx
  import dynamixel_pkg::*;
#(
  parameter int CLK_DIV     = 875,
  parameter int TIMEOUT_CYC = 250000,
  parameter int MAX_PARAMS  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        arm,
  input  logic        RXD,
  output logic        busy,
  output logic        status_valid,
  output logic [31:0] status_word,
  output logic [31:0] param_word,
  output logic        chk_err,
  output logic        frame_err,
  output logic        len_err,
  output logic        timeout
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0] MAX_LEN = 8'(MAX_PARAMS) + MIN_LEN;

  rx_regs_t      r_q, w_d;
  logic [TW-1:0] r_tcnt, w_tcnt;
  logic          w_bv, w_frame, w_abort, w_tmo;
  logic [7:0]    w_byte;

  uart_rx_byte #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk     (clk),
    .rst     (reset),
    .i_rxd   (RXD),
    .i_abort (w_abort),
    .o_valid (w_bv),
    .o_data  (w_byte),
    .o_frame (w_frame)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q    <= '0;
      r_tcnt <= '0;
    end else begin
      r_q    <= w_d;
      r_tcnt <= w_tcnt;
    end
  end

  assign w_tmo = r_q.busy && (r_tcnt == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    w_d     = r_q;
    w_d.sv  = 1'b0;
    w_tcnt  = r_q.busy ? r_tcnt + 1'b1 : r_tcnt;
    w_abort = 1'b0;
    if (arm) begin
      w_d.state     = S_HDR1;
      w_d.busy      = 1'b1;
      w_d.chk_err   = 1'b0;
      w_d.frame_err = 1'b0;
      w_d.len_err   = 1'b0;
      w_d.timeout   = 1'b0;
      w_d.param     = '0;
      w_d.acc       = '0;
      w_d.k         = '0;
      w_tcnt        = '0;
    end else if (w_tmo) begin
      w_d.timeout = 1'b1;
      w_d.busy    = 1'b0;
      w_d.state   = S_IDLE;
      w_abort     = 1'b1;
    end else if (r_q.busy && w_frame) begin
      w_d.frame_err = 1'b1;
      w_d.busy      = 1'b0;
      w_d.state     = S_IDLE;
    end else if (r_q.state == S_DONE) begin
      w_d.sv    = 1'b1;
      w_d.busy  = 1'b0;
      w_d.state = S_IDLE;
    end else if (w_bv) begin
      case (r_q.state)
        S_HDR1: begin
          if (w_byte == HDR_BYTE) w_d.state = S_HDR2;
        end
        S_HDR2: begin
          w_d.state = (w_byte == HDR_BYTE) ? S_ID : S_HDR1;
        end
        S_ID: begin
          // Extra FF bytes are tolerated as part of the header
          if (w_byte != HDR_BYTE) begin
            w_d.id    = w_byte;
            w_d.acc   = w_byte;
            w_d.state = S_LEN;
          end
        end
        S_LEN: begin
          w_d.len = w_byte;
          w_d.acc = r_q.acc + w_byte;
          if (w_byte < MIN_LEN || w_byte > MAX_LEN) begin
            w_d.len_err = 1'b1;
            w_d.busy    = 1'b0;
            w_d.state   = S_IDLE;
          end else begin
            w_d.state = S_ERR;
          end
        end
        S_ERR: begin
          w_d.err   = w_byte;
          w_d.acc   = r_q.acc + w_byte;
          w_d.k     = '0;
          w_d.state = (r_q.len == MIN_LEN) ? S_CHK : S_PARAM;
        end
        S_PARAM: begin
          w_d.param[{r_q.k[1:0], 3'b000} +: 8] = w_byte;
          w_d.acc = r_q.acc + w_byte;
          w_d.k   = r_q.k + 1'b1;
          if (8'(r_q.k) + 8'd1 == r_q.len - MIN_LEN) w_d.state = S_CHK;
        end
        S_CHK: begin
          w_d.chk = w_byte;
          if (w_byte == dxl_checksum(r_q.acc)) begin
            w_d.state = S_DONE;
          end else begin
            w_d.chk_err = 1'b1;
            w_d.busy    = 1'b0;
            w_d.state   = S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy         = r_q.busy;
  assign status_valid = r_q.sv;
  assign status_word  = {r_q.chk, r_q.err, r_q.len, r_q.id};
  assign param_word   = r_q.param;
  assign chk_err      = r_q.chk_err;
  assign frame_err    = r_q.frame_err;
  assign len_err      = r_q.len_err;
  assign timeout      = r_q.timeout;

endmodule

// File: tb/tb_dynamixel_status_rx.sv
// Directed and randomized packet stimulus for dynamixel_status_rx,
// checked against packet-level expectations built in the bench.
module tb_dynamixel_status_rx;

  localparam int DIV  = 16;
  localparam int TMO  = 3000;
  localparam int MAXP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        arm = 1'b0;
  logic        RXD = 1'b1;
  logic        busy, status_valid;
  logic [31:0] status_word, param_word;
  logic        chk_err, frame_err, len_err, timeout;

  int errors = 0;
  int checks = 0;
  int sv_count = 0;
  int sv0;
  logic [7:0] pkt[$];

  dynamixel_status_rx #(
    .CLK_DIV     (DIV),
    .TIMEOUT_CYC (TMO),
    .MAX_PARAMS  (MAXP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .arm          (arm),
    .RXD          (RXD),
    .busy         (busy),
    .status_valid (status_valid),
    .status_word  (status_word),
    .param_word   (param_word),
    .chk_err      (chk_err),
    .frame_err    (frame_err),
    .len_err      (len_err),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (status_valid) sv_count++;

  function automatic logic [31:0] flags();
    return {28'd0, chk_err, frame_err, len_err, timeout};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    RXD = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      tick(DIV);
    end
    RXD = stop;
    tick(DIV);
    RXD = 1'b1;
    tick(DIV);
  endtask

  task automatic send_pkt();
    foreach (pkt[i]) send_byte(pkt[i], 1'b1);
    tick(4);
  endtask

  task automatic do_arm();
    @(negedge clk);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic expect_pkt(input string tag, input int dsv,
                            input logic [31:0] sw, input logic [31:0] pw,
                            input logic [31:0] fl);
    chk({tag, ".sv"}, 32'(sv_count - sv0), 32'(dsv));
    chk({tag, ".sw"}, status_word, sw);
    chk({tag, ".pw"}, param_word, pw);
    chk({tag, ".flags"}, flags(), fl);
    chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [7:0]  id, len, er, ck, sum;
    logic [31:0] pw;
    int          n;
    logic        bad;

    tick(3);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.sv", {31'd0, status_valid}, 32'd0);
    chk("rst.sw", status_word, 32'd0);
    chk("rst.pw", param_word, 32'd0);
    chk("rst.flags", flags(), 32'd0);
    reset = 1'b0;
    tick(4);

    sv0 = sv_count;
    do_arm();
    chk("ping.busy_on", {31'd0, busy}, 32'd1);
    pkt = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h00, 8'hFC};
    send_pkt();
    expect_pkt("ping", 1, 32'hFC000201, 32'h0, 32'h0);

    sv0 = sv_count;
    do_arm();
    pkt = '{8'hFF, 8'hFF, 8'h01, 8'h04, 8'h00, 8'h20, 8'h00, 8'hDA};
    send_pkt();
    expect_pkt("read", 1, 32'hDA000401, 32'h20, 32'h0);

    sv0 = sv_count;
    do_arm();
    pkt = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h00, 8'hFB};
    send_pkt();
    expect_pkt("badchk", 0, 32'hFB000201, 32'h0, 32'h8);

    sv0 = sv_count;
    do_arm();
    pkt = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h03, 8'h02, 8'h04, 8'hF6};
    send_pkt();
    expect_pkt("noise", 1, 32'hF6040203, 32'h0, 32'h0);

    sv0 = sv_count;
    do_arm();
    pkt = '{8'hFF, 8'hFF, 8'h05};
    send_pkt();
    do_arm();
    pkt = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h00, 8'hFC};
    send_pkt();
    expect_pkt("rearm", 1, 32'hFC000201, 32'h0, 32'h0);

    for (int t = 0; t < 8; t++) begin
      id  = 8'($urandom_range(0, 254));
      n   = $urandom_range(0, MAXP);
      er  = 8'($urandom_range(0, 255));
      len = 8'(n + 2);
      bad = ($urandom_range(0, 3) == 0);
      sum = id + len + er;
      pw  = 32'h0;
      pkt = '{8'hFF, 8'hFF, id, len, er};
      for (int i = 0; i < n; i++) begin
        pw[8*i +: 8] = 8'($urandom_range(0, 255));
        sum = sum + pw[8*i +: 8];
        pkt.push_back(pw[8*i +: 8]);
      end
      ck = ~sum;
      if (bad) ck = ck ^ 8'($urandom_range(1, 255));
      pkt.push_back(ck);
      sv0 = sv_count;
      do_arm();
      send_pkt();
      expect_pkt($sformatf("rnd%0d", t), bad ? 0 : 1,
                 {ck, er, len, id}, pw, bad ? 32'h8 : 32'h0);
    end

    sv0 = sv_count;
    do_arm();
    send_byte(8'hFF, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h01, 1'b0);
    tick(4);
    chk("frame.flags", flags(), 32'h4);
    chk("frame.busy", {31'd0, busy}, 32'd0);
    chk("frame.sv", 32'(sv_count - sv0), 32'd0);

    do_arm();
    pkt = '{8'hFF, 8'hFF, 8'h01, 8'h07};
    send_pkt();
    chk("len.flags", flags(), 32'h2);
    chk("len.busy", {31'd0, busy}, 32'd0);

    sv0 = sv_count;
    do_arm();
    tick(TMO - 20);
    chk("tmo.busy_before", {31'd0, busy}, 32'd1);
    tick(40);
    chk("tmo.flags", flags(), 32'h1);
    chk("tmo.busy", {31'd0, busy}, 32'd0);
    chk("tmo.sv", 32'(sv_count - sv0), 32'd0);
    do_arm();
    tick(2);
    chk("tmo.cleared", flags(), 32'h0);
    chk("tmo.rearm_busy", {31'd0, busy}, 32'd1);
    pkt = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h00, 8'hFC};
    send_pkt();
    expect_pkt("tmo.after", 1, 32'hFC000201, 32'h0, 32'h0);

    do_arm();
    pkt = '{8'hFF, 8'hFF, 8'h01, 8'h06, 8'h00, 8'h11};
    send_pkt();
    RXD = 1'b0;
    tick(5);
    chk("mid.busy", {31'd0, busy}, 32'd1);
    chk("mid.pw", param_word, 32'h11);
    reset = 1'b1;
    #1;
    chk("mid.rst_busy", {31'd0, busy}, 32'd0);
    chk("mid.rst_sw", status_word, 32'd0);
    chk("mid.rst_pw", param_word, 32'd0);
    chk("mid.rst_flags", flags(), 32'd0);
    chk("mid.rst_sv", {31'd0, status_valid}, 32'd0);
    RXD = 1'b1;
    tick(2 * DIV);
    reset = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dynamixel_status_rx.md
Name: dynamixel_status_rx

Overview:
- Receive path for the Dynamixel half-duplex bus. Sits downstream of the instruction-packet transmitter and consumes the servo's status packet on RXD once the transmitter has released the line.
- Oversamples the serial line with a clock-cycle divider, assembles bytes, and parses FF FF ID LEN ERR P0..Pn CHK.
- Verifies the checksum, then presents status and parameter words to the NIOS register interface in the existing RX register layout.
- Flags timeout, framing, length and checksum faults.

Parameters:
- CLK_DIV, 875, clk cycles per bit (50 MHz / 875 ≈ 57.14 kbaud).
- TIMEOUT_CYC, 250000, cycles from arm to packet completion before timeout (5 ms).
- MAX_PARAMS, 4, maximum parameter bytes accepted (LEN-2 ≤ MAX_PARAMS).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- arm  in  1  one-cycle pulse: transmitter finished, start listening.
- RXD  in  1  raw serial line, idle high.
- busy  out  1  high from arm until the packet ends or is aborted.
- status_valid  out  1  one-cycle pulse: packet accepted, words updated.
- status_word  out  32  {CHK, ERR, LEN, ID}.
- param_word  out  32  {P3, P2, P1, P0}; unused bytes are 0.
- chk_err  out  1  sticky: checksum mismatch on last packet.
- frame_err  out  1  sticky: stop bit sampled low.
- len_err  out  1  sticky: LEN < 2 or LEN > MAX_PARAMS+2.
- timeout  out  1  sticky: TIMEOUT_CYC elapsed without completion.

Behaviour:
- Reset: every output is 0, the FSM is in IDLE, and the counters are 0.
- RXD sync: 2-flop synchronizer before any use.
- Byte receiver:
  - A falling edge of synced RXD in IDLE_BIT starts a byte.
  - Wait CLK_DIV/2 cycles; if the line is high, it was a glitch; return to idle.
  - Sample 8 data bits LSB-first every CLK_DIV cycles, then the stop bit.
  - Output byte_valid (1 cycle) with the data. A low stop bit gives frame_pulse and no byte_valid.
- Packet FSM states: IDLE, HDR1, HDR2, ID, LEN, ERR, PARAM, CHK, DONE.
  - IDLE: arm → HDR1. Clear all sticky flags, param_word and the checksum accumulator; set busy.
  - HDR1: byte 0xFF → HDR2; any other byte is discarded and the FSM stays in HDR1.
  - HDR2: 0xFF → ID; other byte → HDR1.
  - ID: 0xFF stays in ID (extra header byte); otherwise latch ID, acc=ID, → LEN.
  - LEN: latch LEN, acc+=LEN. LEN outside [2, MAX_PARAMS+2] → set len_err, → IDLE. Otherwise → ERR.
  - ERR: latch ERR, acc+=ERR. If LEN==2 → CHK; else → PARAM with param count 0.
  - PARAM: store the byte into param_word[8k+7:8k], acc+=byte, k++. When k==LEN-2 → CHK.
  - CHK: latch CHK. If CHK == ~acc[7:0], go to DONE; else set chk_err and go to IDLE. status_word is updated in both cases.
  - DONE: status_valid=1 for one cycle, busy=0, → IDLE.
- Checksum: 8-bit accumulator, modulo-256 wrap.
- Timeout: counter runs while busy. At TIMEOUT_CYC, set timeout, drop busy, → IDLE, and abort any byte in progress.
- frame_pulse while busy: set frame_err, → IDLE.
- arm while busy: restart from HDR1 and clear the flags. arm in the same cycle as a completing byte_valid takes priority over it.
- Bytes arriving in IDLE are ignored.
- status_word/param_word hold their values until the next arm.
- Latency: status_valid is asserted 2 cycles after the CHK byte's byte_valid.
- Reset mid-packet: immediate return to the reset state.

Decomposition:
- Package dynamixel_pkg:
  - state enum for the packet FSM.
  - constants HDR_BYTE=8'hFF, MIN_LEN=2.
  - function dxl_checksum (8-bit inverted sum).
- Sub-module uart_rx_byte (CLK_DIV): synchronizer, bit timing, byte_valid/data[7:0]/frame_pulse.

Test Plan:
- Ping reply: arm, then FF FF 01 02 00 FC → one status_valid pulse, status_word=0xFC000201, param_word=0, all flags 0.
- Read reply: FF FF 01 04 00 20 00 DA → status_word=0xDA000401, param_word=0x00000020, chk_err=0.
- Bad checksum: FF FF 01 02 00 FB → no status_valid, chk_err=1, status_word=0xFB000201, busy=0.
- Line noise: arm, then 00 FF FF FF 03 02 04 F6 → status_valid, status_word=0xF6040203.
- Timeout: arm with RXD held high for 250000 cycles → timeout=1, busy=0, no status_valid; a following arm clears timeout.
- Fault paths:
  - Stop bit forced low on the ID byte → frame_err=1, busy=0.
  - LEN=0x07 → len_err=1.
  - Reset asserted mid-PARAM → all outputs 0 at once.
